// File: rtl/work_dispatcher_pkg.sv
// Shared constants, state types and framing helper for the work dispatcher.
package work_dispatcher_pkg;

    localparam logic [7:0] SYNC_RX      = 8'hA5;
    localparam logic [7:0] SYNC_TX      = 8'h5A;
    localparam int         WORK_BYTES   = 84;
    localparam int         BLOCK_BYTES  = 80;
    localparam int         RESULT_BYTES = 4;

    typedef enum logic [1:0] {HUNT, LOAD, CHECK, COMMIT} rx_state_t;
    typedef enum logic       {IDLE, SEND} tx_state_t;

    // Byte 0 of a result frame is the header, bytes 1..4 the nonce MSB first.
    function automatic logic [7:0] frame_byte(input logic [31:0] word, input logic [2:0] idx);
        logic [7:0] b;
        case (idx)
            3'd1:    b = word[31:24];
            3'd2:    b = word[23:16];
            3'd3:    b = word[15:8];
            3'd4:    b = word[7:0];
            default: b = SYNC_TX;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/work_dispatcher_result_fifo.sv
// Synchronous 32-bit result FIFO with show-ahead read data.
// A push into a full FIFO is accepted when a pop happens in the same cycle.
module result_fifo #(
    parameter int DEPTH = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        push,
    input  logic        pop,
    input  logic [31:0] wr_data,
    output logic [31:0] rd_data,
    output logic        full,
    output logic        empty
);

    localparam int AW = $clog2(DEPTH);

    logic [31:0] mem [DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic        do_push;
    logic        do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rd_data = mem[rd_ptr[AW-1:0]];

    // Storage array, written only on an accepted push.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= wr_data;
        end
    end

    // Read and write pointers carry an extra wrap bit to tell full from empty.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

endmodule

// File: rtl/work_dispatcher.sv
// Work dispatcher: assembles framed work packets from the host byte stream,
// launches the miner by pulsing miner_reset, buffers found nonces in a FIFO
// and returns them as 0x5A-headed 5-byte frames.
// Build option: define WORK_CHECKSUM_EN to require a trailing XOR checksum
// byte after the 84 payload bytes; bad packets are dropped silently.
module work_dispatcher
    import work_dispatcher_pkg::*;
#(
    parameter int BLANK_CYCLES = 740,
    parameter int RESET_CYCLES = 2,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [7:0]   rx_data,
    input  logic         rx_valid,
    output logic         rx_ready,
    output logic [7:0]   tx_data,
    output logic         tx_valid,
    input  logic         tx_ready,
    output logic [639:0] block,
    output logic [31:0]  nonce_start,
    output logic         miner_reset,
    input  logic         nonce_found,
    input  logic [31:0]  nonce_out,
    output logic         work_valid,
    output logic         overflow
);

    localparam int BW = (BLANK_CYCLES > 0) ? $clog2(BLANK_CYCLES + 1) : 1;
    localparam int RW = $clog2(RESET_CYCLES + 1);

    rx_state_t      rx_state;
    tx_state_t      tx_state;
    logic [6:0]     byte_idx;
    logic [639:0]   shadow_block;
    logic [31:0]    shadow_nonce;
    logic [7:0]     csum;
    logic [RW-1:0]  rst_cnt;
    logic [BW-1:0]  blank_cnt;
    logic [2:0]     tx_idx;
    logic           rx_accept;
    logic           commit;
    logic           cap_push;
    logic           fifo_pop;
    logic           fifo_full;
    logic           fifo_empty;
    logic [31:0]    fifo_head;

    assign rx_accept = rx_valid && rx_ready;
    assign commit    = (rx_state == COMMIT);
    assign cap_push  = nonce_found && work_valid && !miner_reset;
    assign fifo_pop  = (tx_state == SEND) && tx_valid && tx_ready && (tx_idx == 3'(RESULT_BYTES));

    result_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (cap_push),
        .pop     (fifo_pop),
        .wr_data (nonce_out),
        .rd_data (fifo_head),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // Receive FSM: hunt for sync, shift the packet into shadow registers, then commit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_state     <= HUNT;
            rx_ready     <= 1'b1;
            byte_idx     <= '0;
            shadow_block <= '0;
            shadow_nonce <= '0;
            csum         <= '0;
        end else begin
            case (rx_state)
                HUNT: begin
                    if (rx_accept && rx_data == SYNC_RX) begin
                        rx_state <= LOAD;
                        byte_idx <= '0;
                        csum     <= '0;
                    end
                end
                LOAD: begin
                    if (rx_accept) begin
                        csum     <= csum ^ rx_data;
                        byte_idx <= byte_idx + 7'd1;
                        if (byte_idx < 7'(BLOCK_BYTES)) begin
                            shadow_block <= {shadow_block[631:0], rx_data};
                        end else begin
                            shadow_nonce <= {shadow_nonce[23:0], rx_data};
                        end
                        if (byte_idx == 7'(WORK_BYTES - 1)) begin
`ifdef WORK_CHECKSUM_EN
                            rx_state <= CHECK;
`else
                            rx_state <= COMMIT;
                            rx_ready <= 1'b0;
`endif
                        end
                    end
                end
                CHECK: begin
`ifdef WORK_CHECKSUM_EN
                    if (rx_accept) begin
                        if (rx_data == csum) begin
                            rx_state <= COMMIT;
                            rx_ready <= 1'b0;
                        end else begin
                            rx_state <= HUNT;
                        end
                    end
`else
                    rx_state <= HUNT;
`endif
                end
                default: begin
                    rx_state <= HUNT;
                    rx_ready <= 1'b1;
                end
            endcase
        end
    end

    // Launch sequence: load outputs on commit, hold miner in reset, then blank results.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            block       <= '0;
            nonce_start <= '0;
            miner_reset <= 1'b1;
            rst_cnt     <= '0;
            blank_cnt   <= '0;
            work_valid  <= 1'b0;
        end else if (commit) begin
            block       <= shadow_block;
            nonce_start <= shadow_nonce;
            miner_reset <= 1'b1;
            rst_cnt     <= RW'(RESET_CYCLES);
            blank_cnt   <= BW'(BLANK_CYCLES);
            work_valid  <= 1'b0;
        end else begin
            if (rst_cnt != '0) begin
                rst_cnt <= rst_cnt - 1'b1;
                if (rst_cnt == RW'(1)) begin
                    miner_reset <= 1'b0;
                end
            end
            if (!miner_reset && !work_valid) begin
                if (blank_cnt > BW'(1)) begin
                    blank_cnt <= blank_cnt - 1'b1;
                end else begin
                    blank_cnt  <= '0;
                    work_valid <= 1'b1;
                end
            end
        end
    end

    // Sticky flag for a result lost because the FIFO was full.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overflow <= 1'b0;
        end else if (cap_push && fifo_full && !fifo_pop) begin
            overflow <= 1'b1;
        end
    end

    // Transmit FSM: frame the FIFO head; the entry is popped when its last byte is taken.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tx_state <= IDLE;
            tx_valid <= 1'b0;
            tx_data  <= '0;
            tx_idx   <= '0;
        end else begin
            case (tx_state)
                IDLE: begin
                    if (!fifo_empty) begin
                        tx_state <= SEND;
                        tx_valid <= 1'b1;
                        tx_data  <= SYNC_TX;
                        tx_idx   <= '0;
                    end
                end
                default: begin
                    if (tx_valid && tx_ready) begin
                        if (tx_idx == 3'(RESULT_BYTES)) begin
                            tx_state <= IDLE;
                            tx_valid <= 1'b0;
                        end else begin
                            tx_data <= frame_byte(fifo_head, tx_idx + 3'd1);
                            tx_idx  <= tx_idx + 3'd1;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_work_dispatcher.sv
// Self-checking bench for work_dispatcher: packet loading, launch timing,
// result capture/blanking, FIFO overflow, framing, resync and async reset.
module tb_work_dispatcher;
    import work_dispatcher_pkg::*;

    localparam int DEPTH = 8;
    localparam int BLANK = 740;
    localparam int RSTC  = 2;

    logic         clk;
    logic         reset;
    logic [7:0]   rx_data;
    logic         rx_valid;
    logic         rx_ready;
    logic [7:0]   tx_data;
    logic         tx_valid;
    logic         tx_ready;
    logic [639:0] block;
    logic [31:0]  nonce_start;
    logic         miner_reset;
    logic         nonce_found;
    logic [31:0]  nonce_out;
    logic         work_valid;
    logic         overflow;

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_q[$];
    int model_cnt = 0;
    bit model_ovf = 1'b0;
    int tx_bytes  = 0;
    int frame_pos = 0;

    logic [7:0]   pkt [WORK_BYTES];
    logic [639:0] exp_block;
    logic [31:0]  exp_nonce;

    work_dispatcher #(
        .BLANK_CYCLES (BLANK),
        .RESET_CYCLES (RSTC),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .rx_ready    (rx_ready),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .block       (block),
        .nonce_start (nonce_start),
        .miner_reset (miner_reset),
        .nonce_found (nonce_found),
        .nonce_out   (nonce_out),
        .work_valid  (work_valid),
        .overflow    (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Scoreboard side: every completed tx handshake is matched against the queue.
    always @(negedge clk) begin
        if (!reset && tx_valid && tx_ready) begin
            tx_bytes++;
            if (exp_q.size() == 0) begin
                checkOutput("tx_unexpected_byte", 64'(exp_q.size()), 64'd1);
            end else begin
                checkOutput("tx_byte", 64'(tx_data), 64'(exp_q.pop_front()));
            end
            frame_pos++;
            if (frame_pos == 5) begin
                frame_pos = 0;
                if (model_cnt > 0) model_cnt--;
            end
        end
    end

    task automatic sendByte(input logic [7:0] b);
        int guard;
        rx_data  = b;
        rx_valid = 1'b1;
        guard    = 0;
        while (!rx_ready && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        if (guard >= 50) checkOutput("rx_ready_timeout", 64'(rx_ready), 64'd1);
        @(posedge clk); #1;
        rx_valid = 1'b0;
    endtask

    task automatic buildExpected();
        exp_block = '0;
        exp_nonce = '0;
        for (int i = 0; i < BLOCK_BYTES; i++) exp_block = {exp_block[631:0], pkt[i]};
        for (int i = BLOCK_BYTES; i < WORK_BYTES; i++) exp_nonce = {exp_nonce[23:0], pkt[i]};
    endtask

    task automatic applyStimulus(input bit corrupt);
        logic [7:0] cs;
        cs = 8'h00;
        sendByte(SYNC_RX);
        for (int i = 0; i < WORK_BYTES; i++) begin
            sendByte(pkt[i]);
            cs = cs ^ pkt[i];
        end
`ifdef WORK_CHECKSUM_EN
        sendByte(corrupt ? ~cs : cs);
`else
        if (corrupt) cs = ~cs;
`endif
    endtask

    task automatic checkWork(input string tag);
        for (int k = 0; k < 10; k++) checkOutput({tag, "_block"}, block[k*64 +: 64], exp_block[k*64 +: 64]);
        checkOutput({tag, "_nonce_start"}, 64'(nonce_start), 64'(exp_nonce));
    endtask

    task automatic pulseFound(input logic [31:0] value, input bit expect_capture);
        if (expect_capture) begin
            if (model_cnt < DEPTH) begin
                exp_q.push_back(SYNC_TX);
                exp_q.push_back(value[31:24]);
                exp_q.push_back(value[23:16]);
                exp_q.push_back(value[15:8]);
                exp_q.push_back(value[7:0]);
                model_cnt++;
            end else begin
                model_ovf = 1'b1;
            end
        end
        nonce_out   = value;
        nonce_found = 1'b1;
        @(posedge clk); #1;
        nonce_found = 1'b0;
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_block"}, 64'(block == '0), 64'd1);
        checkOutput({tag, "_nonce_start"}, 64'(nonce_start), 64'd0);
        checkOutput({tag, "_miner_reset"}, 64'(miner_reset), 64'd1);
        checkOutput({tag, "_work_valid"}, 64'(work_valid), 64'd0);
        checkOutput({tag, "_overflow"}, 64'(overflow), 64'd0);
        checkOutput({tag, "_tx_valid"}, 64'(tx_valid), 64'd0);
        checkOutput({tag, "_tx_data"}, 64'(tx_data), 64'd0);
        checkOutput({tag, "_rx_ready"}, 64'(rx_ready), 64'd1);
    endtask

    // Watchdog so the bench can never hang.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int n;
        reset       = 1'b1;
        rx_data     = 8'h00;
        rx_valid    = 1'b0;
        tx_ready    = 1'b1;
        nonce_found = 1'b0;
        nonce_out   = 32'h0;
        #1;
        checkResetValues("reset");
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk); #1;
        checkOutput("post_reset_rx_ready", 64'(rx_ready), 64'd1);

        // Load 0x00..0x53 and time the launch sequence.
        for (int i = 0; i < WORK_BYTES; i++) pkt[i] = 8'(i);
        buildExpected();
        applyStimulus(1'b0);
        checkOutput("commit_rx_ready", 64'(rx_ready), 64'd0);
        @(posedge clk); #1;
        checkOutput("first_byte", 64'(block[639:632]), 64'h00);
        checkOutput("last_block_byte", 64'(block[7:0]), 64'h4F);
        checkOutput("nonce_start_seq", 64'(nonce_start), 64'h50515253);
        checkWork("load1");
        n = 0;
        while (miner_reset && n < 20) begin
            n++;
            @(posedge clk); #1;
        end
        checkOutput("miner_reset_cycles", 64'(n), 64'(RSTC));
        n = 0;
        while (!work_valid && n < 2000) begin
            if (n == 100) begin
                nonce_out   = 32'h11111111;
                nonce_found = 1'b1;
            end
            if (n == 101) nonce_found = 1'b0;
            @(posedge clk); #1;
            n++;
        end
        checkOutput("blank_cycles", 64'(n), 64'(BLANK));
        checkOutput("blank_no_tx", 64'(tx_valid), 64'd0);

        // A found nonce after blanking produces one frame.
        pulseFound(32'hDEADBEEF, 1'b1);
        repeat (20) @(posedge clk);
        #1;
        checkOutput("deadbeef_drained", 64'(exp_q.size()), 64'd0);
        checkOutput("deadbeef_bytes", 64'(tx_bytes), 64'd5);

        // Back-pressure: 9 results against a stalled host.
        tx_ready = 1'b0;
        for (int i = 0; i < 9; i++) pulseFound({8'hC0, 8'(i), 16'hBEEF}, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        checkOutput("overflow_set", 64'(overflow), 64'(model_ovf));
        checkOutput("stall_valid", 64'(tx_valid), 64'd1);
        checkOutput("stall_header", 64'(tx_data), 64'(SYNC_TX));
        repeat (5) @(posedge clk);
        #1;
        checkOutput("stall_header_hold", 64'(tx_data), 64'(SYNC_TX));
        tx_ready = 1'b1;
        repeat (100) @(posedge clk);
        #1;
        checkOutput("overflow_drained", 64'(exp_q.size()), 64'd0);
        checkOutput("overflow_frames_bytes", 64'(tx_bytes), 64'd45);
        checkOutput("overflow_sticky", 64'(overflow), 64'd1);

        // Garbage before sync, then a reload while mining.
        sendByte(8'h00);
        sendByte(8'h5A);
        sendByte(8'hFF);
        for (int i = 0; i < WORK_BYTES; i++) pkt[i] = 8'(i * 7 + 3);
        buildExpected();
        applyStimulus(1'b0);
        @(posedge clk); #1;
        checkWork("resync");
        checkOutput("reload_miner_reset", 64'(miner_reset), 64'd1);
        checkOutput("reload_work_valid", 64'(work_valid), 64'd0);

        // Asynchronous reset in the middle of a packet.
        sendByte(SYNC_RX);
        for (int i = 0; i < 30; i++) sendByte(8'(i + 100));
        #3 reset = 1'b1;
        exp_q.delete();
        model_cnt = 0;
        model_ovf = 1'b0;
        frame_pos = 0;
        #1;
        checkResetValues("async_reset");
        @(posedge clk); #1;
        reset = 1'b0;
        for (int i = 0; i < WORK_BYTES; i++) pkt[i] = 8'(255 - i);
        buildExpected();
        applyStimulus(1'b0);
        @(posedge clk); #1;
        checkWork("after_reset");
        checkOutput("after_reset_miner_reset", 64'(miner_reset), 64'd1);

`ifdef WORK_CHECKSUM_EN
        // A bad checksum must leave running work and miner_reset untouched.
        repeat (5) @(posedge clk);
        #1;
        for (int i = 0; i < WORK_BYTES; i++) pkt[i] = 8'(i ^ 8'h3C);
        applyStimulus(1'b1);
        n = 0;
        for (int i = 0; i < 6; i++) begin
            if (miner_reset) n++;
            @(posedge clk); #1;
        end
        checkOutput("bad_csum_no_launch", 64'(n), 64'd0);
        checkWork("bad_csum_kept");
        buildExpected();
        applyStimulus(1'b0);
        @(posedge clk); #1;
        checkWork("good_csum");
        checkOutput("good_csum_miner_reset", 64'(miner_reset), 64'd1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/work_dispatcher.md
Name: work_dispatcher

Overview:
Host-side counterpart of the miner core. Assembles work packets from a byte stream into the 640-bit block plus nonce_start and launches the miner by pulsing its reset. Captures nonce_found/nonce_out results into a FIFO and serialises them back as framed bytes. Sits between the host link (UART/PCIe shim byte interface) and one miner instance.

Parameters:
BLANK_CYCLES, 740, cycles after miner launch during which nonce_found is ignored (pipeline fill)
RESET_CYCLES, 2, cycles miner_reset is held high on launch (min 1)
FIFO_DEPTH, 8, result FIFO entries (power of 2, >=2)

Ports:
clk  in  1  clock
reset  in  1  reset; asynchronous, active-high
rx_data  in  8  work byte from host
rx_valid  in  1  rx_data valid
rx_ready  out  1  dispatcher accepts byte (handshake when rx_valid&rx_ready)
tx_data  out  8  result byte to host
tx_valid  out  1  tx_data valid
tx_ready  in  1  host accepts tx byte
block  out  640  to miner: midstate[639:128], data[127:32], target[31:0]
nonce_start  out  32  to miner
miner_reset  out  1  to miner reset input
nonce_found  in  1  from miner
nonce_out  in  32  from miner
work_valid  out  1  high once committed work is running and blanking expired
overflow  out  1  sticky: a result was dropped on full FIFO

Behaviour:
- Reset (async assert, sync release): block=0, nonce_start=0, miner_reset=1, work_valid=0, overflow=0, tx_valid=0, tx_data=0, rx_ready=1, FIFO empty, RX FSM in HUNT.
- RX FSM: HUNT -> LOAD on accepted byte 0xA5; other bytes discarded. LOAD accepts 84 bytes: bytes 0..79 into shadow block, first byte -> [639:632]; bytes 80..83 into shadow nonce, MSB first. After byte 83 -> COMMIT (CHECK if WORK_CHECKSUM_EN). 0xA5 inside LOAD is data, not resync.
- COMMIT (1 cycle, rx_ready=0): block and nonce_start updated from shadow in the same cycle; miner_reset=1 for RESET_CYCLES cycles starting next cycle; blank counter loaded with BLANK_CYCLES, starts when miner_reset drops; work_valid=0 until counter reaches 0. FSM -> HUNT. Outputs block/nonce_start stable except at COMMIT.
- New work while mining: reload restarts the launch sequence; blanking restarts; FIFO contents kept (old results valid).
- Capture: push nonce_out when nonce_found && work_valid && !miner_reset. Full and no pop same cycle -> drop, overflow=1 (sticky until reset). Full with pop same cycle -> push accepted.
- TX FSM: IDLE -> when FIFO non-empty, pop and send 5 bytes: 0x5A header then nonce MSB first. Byte advances only on tx_valid&tx_ready; tx_data stable while tx_valid&!tx_ready. No gap cycle required between frames.
- Counters: byte index 7-bit, wraps never (bounded by FSM); blank counter saturates at 0.

Optional Feature:
WORK_CHECKSUM_EN: defined -> after byte 83, one extra byte (XOR of all 84 payload bytes) is received in CHECK; mismatch -> discard shadow, no COMMIT, back to HUNT, running work untouched. Undefined -> no checksum byte; COMMIT directly after byte 83.

Decomposition:
- Package work_dispatcher_pkg: SYNC_RX=8'hA5, SYNC_TX=8'h5A, WORK_BYTES=84, RESULT_BYTES=4, rx_state_t {HUNT, LOAD, CHECK, COMMIT}, tx_state_t {IDLE, SEND}.
- One sub-module: result_fifo (sync FIFO, 32-bit, FIFO_DEPTH, push/pop/full/empty, simultaneous push+pop on full allowed).

Test Plan:
- Send 0xA5 + bytes 0x00..0x53 -> block[639:632]=0x00, block[7:0]=0x4F, nonce_start=0x50515253; miner_reset high exactly 2 cycles after COMMIT; work_valid rises 740 cycles after miner_reset falls.
- nonce_found pulse during blanking with nonce_out=0x11111111 -> no tx bytes; after work_valid, pulse with 0xDEADBEEF -> tx 5A DE AD BE EF.
- tx_ready held low, 9 found pulses -> 8 stored, overflow=1; release tx_ready -> exactly 8 frames in push order.
- Garbage bytes 0x00,0x5A,0xFF before 0xA5 -> ignored; work loads correctly; async reset mid-LOAD -> all outputs to reset values, next 0xA5 loads cleanly.
- WORK_CHECKSUM_EN: correct checksum -> commit; corrupted checksum -> block/nonce_start unchanged, no miner_reset pulse.
